hdmi_timing_gen: RTL and testbench
==================================

Name: hdmi_timing_gen

Overview:
- Video timing and HDMI control-period generator for the 800x480x60Hz pipeline on hdmi_clk.
- Produces blank/hsync/vsync, pixel coordinates and the preamble/guard/data-island qualifiers consumed directly by video_encoder, the font generator and the overlay blocks.
- Timing is parameterised; the data-island placement is deterministic per line.

Parameters:
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch clocks
- H_SYNC, 128, hsync width clocks
- H_BP, 88, horizontal back porch clocks (H_TOTAL = 1056)
- V_ACTIVE, 480, active lines
- V_FP, 13, vertical front porch lines
- V_SYNC, 3, vsync width lines
- V_BP, 29, vertical back porch lines (V_TOTAL = 525)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- DI_OFFSET, 4, control clocks between end of active and data preamble
- DI_PACKETS, 1, 32-clock packets per data island

Ports:
- clk, in, 1, pixel clock (hdmi_clk)
- reset, in, 1, asynchronous active-high reset
- blank, out, 1, 1 outside active area
- hsync, out, 1, horizontal sync at HSYNC_POL
- vsync, out, 1, vertical sync at VSYNC_POL
- pix_x, out, 11, horizontal position of current outputs
- pix_y, out, 10, vertical position of current outputs
- frame_start, out, 1, one-clock pulse at (0,0)
- video_preamble, out, 1, video preamble period
- video_guard, out, 1, video leading guard band
- data_preamble, out, 1, data-island preamble period
- data_guard, out, 1, data-island leading/trailing guard band
- data_island, out, 1, data-island packet period

Behaviour:
- Counters:
  - hcnt counts 0..H_TOTAL-1 and wraps.
  - vcnt increments when hcnt wraps and itself wraps V_TOTAL-1 -> 0.
- Outputs:
  - Every output is a register computed from (hcnt, vcnt), giving 1-clock latency.
  - pix_x/pix_y equal the position the other outputs describe.
- Reset (async):
  - hcnt = vcnt = 0, blank = 1, hsync = !HSYNC_POL, vsync = !VSYNC_POL.
  - pix_x = pix_y = 0; frame_start and all control qualifiers = 0.
  - Reset mid-frame restarts from (0,0) with no partial flags.
  - The first edge after release presents position (0,0) with frame_start = 1.
- Timing regions:
  - active = (x < H_ACTIVE) && (y < V_ACTIVE); blank = !active.
  - hsync asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), over the whole line (changes at x = 0).
- Video control:
  - Only on line y where the next line is active, i.e. (y+1) mod V_TOTAL < V_ACTIVE. This includes y = V_TOTAL-1 and excludes y = V_ACTIVE-1.
  - video_preamble for x in [H_TOTAL-10, H_TOTAL-2).
  - video_guard for x in [H_TOTAL-2, H_TOTAL-1].
- Data-island sequence: every line, as a state machine with states CTRL -> DPRE(8) -> DGUARD_L(2) -> ISLAND(32*DI_PACKETS) -> DGUARD_T(2) -> CTRL.
  - CTRL -> DPRE when x == H_ACTIVE+DI_OFFSET.
  - Each state's length is counted by a down-counter.
  - data_guard is high in both guard states.
- Exclusivity: at most one of the five qualifiers is high in any clock, and none is high while blank = 0.
- Elaboration check: H_ACTIVE+DI_OFFSET+12+32*DI_PACKETS <= H_TOTAL-14. Violation is $fatal.

Optional Feature:
- Macro: HDMI_TIMING_DATA_ISLAND_EN.
- Defined: data-island FSM is present as described.
- Undefined:
  - FSM is omitted; data_preamble, data_guard and data_island are tied 0 (DVI-style control periods).
  - Video preamble/guard are unchanged.
  - The DI_OFFSET/DI_PACKETS elaboration check is skipped.

Decomposition:
- Package hdmi_timing_pkg:
  - Default 800x480 timing constants.
  - PREAMBLE_LEN = 8, GUARD_LEN = 2, PACKET_LEN = 32.
  - typedef enum di_state_t {CTRL, DPRE, DGUARD_L, ISLAND, DGUARD_T}.
- Sub-module hdmi_island_fsm:
  - Inputs: clk, reset, start.
  - Outputs: the three data qualifiers.
  - Instantiated under the macro.

Test Plan:
- Reset then run 1 frame -> frame_start pulses once per 554400 clocks; pix_x wraps 1055->0; pix_y wraps 524->0.
- Line y=0 -> blank=0 for pix_x 0..799; hsync=0 exactly for pix_x 840..967; blank=1 elsewhere.
- Lines 0..524 -> vsync=0 only for pix_y 493..495; video_preamble high at pix_x 1046..1053 and video_guard at 1054..1055 only on pix_y 479? no, 524 and 0..478.
  - Required: lines 0..478 and 524 have it; lines 479..523 have no video qualifiers.
- Macro defined, any line -> data_preamble at pix_x 804..811, data_guard at 812..813 and 846..847, data_island at 814..845.
  - Checker asserts one-hot-or-zero of the five qualifiers every clock.
- Assert reset at (pix_x=820, pix_y=100) for 3 clocks -> outputs take reset values asynchronously; first post-release output is (0,0) with frame_start=1 and no stale data_island.
- Macro undefined -> data qualifiers constant 0 across a full frame; all other outputs bit-identical to the defined build.

Source files
------------

// File: rtl/hdmi_timing_pkg.sv
// Shared constants and types for the HDMI timing generator.
// The data-island sequencer is built only with HDMI_TIMING_DATA_ISLAND_EN defined.
package hdmi_timing_pkg;

  localparam int H_ACTIVE_DEF   = 800;
  localparam int H_FP_DEF       = 40;
  localparam int H_SYNC_DEF     = 128;
  localparam int H_BP_DEF       = 88;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int V_FP_DEF       = 13;
  localparam int V_SYNC_DEF     = 3;
  localparam int V_BP_DEF       = 29;
  localparam int HSYNC_POL_DEF  = 0;
  localparam int VSYNC_POL_DEF  = 0;
  localparam int DI_OFFSET_DEF  = 4;
  localparam int DI_PACKETS_DEF = 1;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;

  typedef enum logic [2:0] {CTRL, DPRE, DGUARD_L, ISLAND, DGUARD_T} di_state_t;

  // Clocks from the first data preamble clock to the end of the trailing guard band.
  function automatic int di_span(input int packets);
    return PREAMBLE_LEN + 2 * GUARD_LEN + PACKET_LEN * packets;
  endfunction

endpackage

// File: rtl/hdmi_timing_if.sv
// Video timing bundle from hdmi_timing_gen to the encoder, font and overlay blocks.
interface hdmi_timing_if;

  logic        blank;
  logic        hsync;
  logic        vsync;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        frame_start;
  logic        video_preamble;
  logic        video_guard;
  logic        data_preamble;
  logic        data_guard;
  logic        data_island;

  modport master (
    output blank, hsync, vsync, pix_x, pix_y, frame_start,
           video_preamble, video_guard, data_preamble, data_guard, data_island
  );

  modport slave (
    input blank, hsync, vsync, pix_x, pix_y, frame_start,
          video_preamble, video_guard, data_preamble, data_guard, data_island
  );

endinterface

// File: rtl/hdmi_island_fsm.sv
// Per-line data-island sequencer: preamble, leading guard, packets, trailing guard.
// Qualifiers are registered from the next state so they line up with the registered pixel position.
module hdmi_island_fsm
  import hdmi_timing_pkg::*;
#(
  parameter int DI_PACKETS = DI_PACKETS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic data_preamble,
  output logic data_guard,
  output logic data_island
);

  localparam int ISLAND_LEN = PACKET_LEN * DI_PACKETS;
  localparam int CW         = $clog2(ISLAND_LEN + 1);

  di_state_t       state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= CTRL;
      cnt           <= '0;
      data_preamble <= 1'b0;
      data_guard    <= 1'b0;
      data_island   <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      data_preamble <= (state_nx == DPRE);
      data_guard    <= (state_nx == DGUARD_L) || (state_nx == DGUARD_T);
      data_island   <= (state_nx == ISLAND);
    end
  end

  // Each state loads the down-counter with its length minus one and leaves when it reaches zero.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt - CW'(1);
    unique case (state)
      CTRL: begin
        cnt_nx = cnt;
        if (start) begin
          state_nx = DPRE;
          cnt_nx   = CW'(PREAMBLE_LEN - 1);
        end
      end
      DPRE: if (cnt == '0) begin
        state_nx = DGUARD_L;
        cnt_nx   = CW'(GUARD_LEN - 1);
      end
      DGUARD_L: if (cnt == '0) begin
        state_nx = ISLAND;
        cnt_nx   = CW'(ISLAND_LEN - 1);
      end
      ISLAND: if (cnt == '0) begin
        state_nx = DGUARD_T;
        cnt_nx   = CW'(GUARD_LEN - 1);
      end
      DGUARD_T: if (cnt == '0) begin
        state_nx = CTRL;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = CTRL;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hdmi_timing_gen.sv
// Video timing and HDMI control-period generator; all outputs are registered from (hcnt, vcnt).
// Define HDMI_TIMING_DATA_ISLAND_EN to build the data-island sequencer; otherwise data qualifiers are 0.
module hdmi_timing_gen
  import hdmi_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int HSYNC_POL  = HSYNC_POL_DEF,
  parameter int VSYNC_POL  = VSYNC_POL_DEF,
  parameter int DI_OFFSET  = DI_OFFSET_DEF,
  parameter int DI_PACKETS = DI_PACKETS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  hdmi_timing_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_MAX    = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VP_BEG   = 11'(H_TOTAL - 10);
  localparam logic [10:0] VG_BEG   = 11'(H_TOTAL - 2);
  localparam logic [9:0]  V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ON    = 1'(HSYNC_POL);
  localparam logic        VS_ON    = 1'(VSYNC_POL);

  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic        active, hs_in, vs_in, next_line_active, vp_in, vg_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_MAX) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_MAX) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 11'd1;
    end
  end

  // Video preamble/guard announce an active line, so they run at the end of the line before it.
  always_comb begin
    active           = (hcnt < H_ACT) && (vcnt < V_ACT);
    hs_in            = (hcnt >= HS_BEG) && (hcnt < HS_END);
    vs_in            = (vcnt >= VS_BEG) && (vcnt < VS_END);
    next_line_active = (vcnt == V_MAX) || (vcnt < V_LAST);
    vp_in            = next_line_active && (hcnt >= VP_BEG) && (hcnt < VG_BEG);
    vg_in            = next_line_active && (hcnt >= VG_BEG);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid.blank          <= 1'b1;
      vid.hsync          <= ~HS_ON;
      vid.vsync          <= ~VS_ON;
      vid.pix_x          <= '0;
      vid.pix_y          <= '0;
      vid.frame_start    <= 1'b0;
      vid.video_preamble <= 1'b0;
      vid.video_guard    <= 1'b0;
    end else begin
      vid.blank          <= ~active;
      vid.hsync          <= hs_in ? HS_ON : ~HS_ON;
      vid.vsync          <= vs_in ? VS_ON : ~VS_ON;
      vid.pix_x          <= hcnt;
      vid.pix_y          <= vcnt;
      vid.frame_start    <= (hcnt == '0) && (vcnt == '0);
      vid.video_preamble <= vp_in;
      vid.video_guard    <= vg_in;
    end
  end

`ifdef HDMI_TIMING_DATA_ISLAND_EN
  localparam logic [10:0] DI_START = 11'(H_ACTIVE + DI_OFFSET);

  // The island must finish before the video preamble window of the same line.
  if (H_ACTIVE + DI_OFFSET + di_span(DI_PACKETS) > H_TOTAL - 14) begin : g_di_fit_check
    $fatal(1, "hdmi_timing_gen: data island does not fit in horizontal blanking");
  end

  hdmi_island_fsm #(
    .DI_PACKETS (DI_PACKETS)
  ) u_island_fsm (
    .clk           (clk),
    .reset         (reset),
    .start         (hcnt == DI_START),
    .data_preamble (vid.data_preamble),
    .data_guard    (vid.data_guard),
    .data_island   (vid.data_island)
  );
`else
  assign vid.data_preamble = 1'b0;
  assign vid.data_guard    = 1'b0;
  assign vid.data_island   = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: a default-timing DUT and a shrunken-timing DUT checked every clock
// against an interval-arithmetic model, with randomly placed asynchronous resets.
module tb_hdmi_timing_gen;
  import hdmi_timing_pkg::*;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int hpol; int vpol; int off; int np;
  } timing_t;

  localparam timing_t DEF = '{ha:800, hfp:40, hs:128, hbp:88, va:480, vfp:13, vs:3, vbp:29,
                               hpol:0, vpol:0, off:4, np:1};
  localparam timing_t SML = '{ha:64, hfp:60, hs:20, hbp:20, va:20, vfp:3, vs:2, vbp:4,
                               hpol:1, vpol:1, off:6, np:2};
  localparam int SML_HT    = 164;
  localparam int SML_FRAME = SML_HT * 29;

  logic clk = 1'b0;
  logic reset;
  int   checks;
  int   errors;
  int   p;
  int   fs_count;

  always #5 clk = ~clk;

  hdmi_timing_if vid_def ();
  hdmi_timing_if vid_sml ();

  hdmi_timing_gen u_dut_def (
    .clk   (clk),
    .reset (reset),
    .vid   (vid_def)
  );

  hdmi_timing_gen #(
    .H_ACTIVE (SML.ha), .H_FP (SML.hfp), .H_SYNC (SML.hs), .H_BP (SML.hbp),
    .V_ACTIVE (SML.va), .V_FP (SML.vfp), .V_SYNC (SML.vs), .V_BP (SML.vbp),
    .HSYNC_POL (SML.hpol), .VSYNC_POL (SML.vpol),
    .DI_OFFSET (SML.off), .DI_PACKETS (SML.np)
  ) u_dut_sml (
    .clk   (clk),
    .reset (reset),
    .vid   (vid_sml)
  );

  // Packed view: {blank, hsync, vsync, frame_start, vp, vg, dp, dg, di, pix_y, pix_x}.
  logic [29:0] obs_def, obs_sml;
  assign obs_def = {vid_def.blank, vid_def.hsync, vid_def.vsync, vid_def.frame_start,
                    vid_def.video_preamble, vid_def.video_guard, vid_def.data_preamble,
                    vid_def.data_guard, vid_def.data_island, vid_def.pix_y, vid_def.pix_x};
  assign obs_sml = {vid_sml.blank, vid_sml.hsync, vid_sml.vsync, vid_sml.frame_start,
                    vid_sml.video_preamble, vid_sml.video_guard, vid_sml.data_preamble,
                    vid_sml.data_guard, vid_sml.data_island, vid_sml.pix_y, vid_sml.pix_x};

  function automatic logic [29:0] reset_vec(input timing_t t);
    return {1'b1, ~t.hpol[0], ~t.vpol[0], 27'd0};
  endfunction

  // Expected outputs for the p-th clock since reset release, straight from the region rules.
  function automatic logic [29:0] model(input int pos, input timing_t t);
    int   ht, vt, x, y;
    logic act, hs, vs, nxt, vp, vg, dp, dg, di;
    ht  = t.ha + t.hfp + t.hs + t.hbp;
    vt  = t.va + t.vfp + t.vs + t.vbp;
    x   = pos % ht;
    y   = (pos / ht) % vt;
    act = (x < t.ha) && (y < t.va);
    hs  = (x >= t.ha + t.hfp) && (x < t.ha + t.hfp + t.hs);
    vs  = (y >= t.va + t.vfp) && (y < t.va + t.vfp + t.vs);
    nxt = ((y + 1) % vt) < t.va;
    vp  = nxt && (x >= ht - 10) && (x < ht - 2);
    vg  = nxt && (x >= ht - 2);
`ifdef HDMI_TIMING_DATA_ISLAND_EN
    begin
      int d0, isl;
      d0  = t.ha + t.off;
      isl = 32 * t.np;
      dp  = (x >= d0) && (x < d0 + 8);
      dg  = ((x >= d0 + 8) && (x < d0 + 10)) || ((x >= d0 + 10 + isl) && (x < d0 + 12 + isl));
      di  = (x >= d0 + 10) && (x < d0 + 10 + isl);
    end
`else
    dp = 1'b0;
    dg = 1'b0;
    di = 1'b0;
`endif
    return {~act, hs ? t.hpol[0] : ~t.hpol[0], vs ? t.vpol[0] : ~t.vpol[0],
            (x == 0) && (y == 0), vp, vg, dp, dg, di, 10'(y), 11'(x)};
  endfunction

  task automatic checkOutput(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at p=%0d: got %h, expected %h", tag, p, obs, exp);
    end
  endtask

  // Free-run n clocks, checking both DUTs and qualifier exclusivity after every edge.
  task automatic runCycles(input int n);
    logic excl_ok;
    for (int i = 0; i < n && errors <= 40; i++) begin
      @(negedge clk);
      checkOutput("def", obs_def, model(p, DEF));
      checkOutput("sml", obs_sml, model(p, SML));
      excl_ok = ($countones(obs_sml[25:21]) <= 1) && (obs_sml[29] || (obs_sml[25:21] == 5'd0));
      checkOutput("excl", 30'(excl_ok), 30'd1);
      if (obs_sml[26]) fs_count++;
      p++;
    end
  endtask

  // Run n clocks, then pulse reset between edges and confirm outputs clear without a clock.
  task automatic applyStimulus(input int n);
    runCycles(n);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_def", obs_def, reset_vec(DEF));
    checkOutput("async_rst_sml", obs_sml, reset_vec(SML));
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("held_rst_sml", obs_sml, reset_vec(SML));
    reset = 1'b0;
    p     = 0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    p        = 0;
    fs_count = 0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_def", obs_def, reset_vec(DEF));
    checkOutput("rst_sml", obs_sml, reset_vec(SML));
    reset = 1'b0;
    $display("[TB] reset released, running two shrunken frames");

    runCycles(2 * SML_FRAME + 100);
    checkOutput("fs_count", 30'(fs_count), 30'd3);

    applyStimulus(1);
    // Lands inside the packet period of line 10 on the shrunken DUT.
    applyStimulus(10 * SML_HT + SML.ha + SML.off + 20);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(int'($urandom_range(1, 2500)));
    end

    $display("[TB] long run on default timing");
    runCycles(40000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
